// File: rtl/ucie_ctl_phy_mm_data_transfer.sv
// rtl/ucie_ctl_phy_mm_data_transfer.sv - UCIe PHY mainband data transfer: TX FIFO with parity, RX forward with parity check
module ucie_ctl_phy_mm_data_transfer #(
    parameter int NBYTES = 8,
    parameter int NMOD   = 2,
    parameter int DEPTH  = 4,
    parameter int ERRW   = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_enable,
    input  logic                  i_rdi_lp_irdy,
    input  logic                  i_rdi_lp_valid,
    input  logic [NBYTES*8-1:0]   i_rdi_lp_data,
    output logic                  o_rdi_pl_trdy,
    output logic [NBYTES*8-1:0]   o_data_sent,
    output logic                  o_data_valid,
    output logic [NMOD-1:0]       o_data_par,
    input  logic                  i_link_ready,
    input  logic [NBYTES*8-1:0]   i_data_received,
    input  logic                  i_data_valid,
    input  logic [NMOD-1:0]       i_data_par,
    output logic                  o_rdi_pl_valid,
    output logic [NBYTES*8-1:0]   o_rdi_pl_data,
    input  logic                  i_phy_req_data_error,
    input  logic                  i_clr_err_cnt,
    output logic                  o_par_err,
    output logic [ERRW-1:0]       o_par_err_cnt,
    output logic                  o_tx_empty
);

    localparam int W   = NBYTES * 8;
    localparam int SEG = W / NMOD;
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = AW + 1;

    logic [W-1:0]    r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_inject_pend;

    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic [NMOD-1:0] w_tx_par;
    logic [NMOD-1:0] w_rx_par;
    logic            w_rx_take;
    logic            w_rx_bad;

    assign w_full        = (r_count == CW'(DEPTH));
    assign w_empty       = (r_count == '0);
    // Reset gating keeps trdy/valid low even before the first reset edge lands.
    assign o_rdi_pl_trdy = i_rst_n & i_enable & ~w_full;
    assign o_data_valid  = i_rst_n & i_enable & ~w_empty;
    assign o_tx_empty    = w_empty;
    assign o_data_sent   = r_mem[r_rd_ptr];

    assign w_push = i_rdi_lp_irdy & i_rdi_lp_valid & o_rdi_pl_trdy;
    assign w_pop  = o_data_valid & i_link_ready;

    always_comb begin
        w_tx_par = '0;
        w_rx_par = '0;
        for (int m = 0; m < NMOD; m++) begin
            w_tx_par[m] = ^o_data_sent[m*SEG +: SEG];
            w_rx_par[m] = ^i_data_received[m*SEG +: SEG];
        end
    end

    // Parity is forced to zero while nothing is buffered; injection still flips bit 0.
    assign o_data_par = (w_empty ? '0 : w_tx_par) ^ NMOD'(r_inject_pend);

    assign w_rx_take = i_enable & i_data_valid;
    assign w_rx_bad  = w_rx_take & (w_rx_par != i_data_par);

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_rdi_lp_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || !i_enable) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_inject_pend <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            if (r_inject_pend && w_pop) begin
                r_inject_pend <= 1'b0;
            end else if (!r_inject_pend && i_phy_req_data_error) begin
                r_inject_pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_rdi_pl_valid <= 1'b0;
            o_rdi_pl_data  <= '0;
            o_par_err      <= 1'b0;
            o_par_err_cnt  <= '0;
        end else begin
            o_rdi_pl_valid <= w_rx_take;
            o_par_err      <= w_rx_bad;
            if (w_rx_take) begin
                o_rdi_pl_data <= i_data_received;
            end
            if (i_clr_err_cnt) begin
                o_par_err_cnt <= '0;
            end else if (w_rx_bad && (o_par_err_cnt != '1)) begin
                o_par_err_cnt <= o_par_err_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ucie_ctl_phy_mm_data_transfer.sv
// tb/tb_ucie_ctl_phy_mm_data_transfer.sv - directed self-checking bench for ucie_ctl_phy_mm_data_transfer
module tb_ucie_ctl_phy_mm_data_transfer;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_enable;
    logic        i_rdi_lp_irdy;
    logic        i_rdi_lp_valid;
    logic [63:0] i_rdi_lp_data;
    logic        o_rdi_pl_trdy;
    logic [63:0] o_data_sent;
    logic        o_data_valid;
    logic [1:0]  o_data_par;
    logic        i_link_ready;
    logic [63:0] i_data_received;
    logic        i_data_valid;
    logic [1:0]  i_data_par;
    logic        o_rdi_pl_valid;
    logic [63:0] o_rdi_pl_data;
    logic        i_phy_req_data_error;
    logic        i_clr_err_cnt;
    logic        o_par_err;
    logic [7:0]  o_par_err_cnt;
    logic        o_tx_empty;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 i_clk = ~i_clk;

    ucie_ctl_phy_mm_data_transfer #(.NBYTES(8), .NMOD(2), .DEPTH(4), .ERRW(8)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_enable(i_enable),
        .i_rdi_lp_irdy(i_rdi_lp_irdy), .i_rdi_lp_valid(i_rdi_lp_valid), .i_rdi_lp_data(i_rdi_lp_data),
        .o_rdi_pl_trdy(o_rdi_pl_trdy), .o_data_sent(o_data_sent), .o_data_valid(o_data_valid),
        .o_data_par(o_data_par), .i_link_ready(i_link_ready), .i_data_received(i_data_received),
        .i_data_valid(i_data_valid), .i_data_par(i_data_par), .o_rdi_pl_valid(o_rdi_pl_valid),
        .o_rdi_pl_data(o_rdi_pl_data), .i_phy_req_data_error(i_phy_req_data_error),
        .i_clr_err_cnt(i_clr_err_cnt), .o_par_err(o_par_err), .o_par_err_cnt(o_par_err_cnt),
        .o_tx_empty(o_tx_empty)
    );

    task automatic cycle();
        @(posedge i_clk);
        #2;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0; i_enable = 1'b1; i_rdi_lp_irdy = 1'b1; i_rdi_lp_valid = 1'b1;
        i_rdi_lp_data = 64'hAA; i_link_ready = 1'b0; i_data_received = '0; i_data_valid = 1'b0;
        i_data_par = '0; i_phy_req_data_error = 1'b0; i_clr_err_cnt = 1'b0;
        cycle(); cycle();
        n_checks++; if (o_rdi_pl_trdy !== 1'b0) $display("FAIL reset_trdy got %0b exp 0", o_rdi_pl_trdy); else n_pass++;
        n_checks++; if (o_data_valid !== 1'b0) $display("FAIL reset_data_valid got %0b exp 0", o_data_valid); else n_pass++;
        n_checks++; if (o_par_err_cnt !== 8'd0) $display("FAIL reset_err_cnt got %0d exp 0", o_par_err_cnt); else n_pass++;
        n_checks++; if (o_tx_empty !== 1'b1) $display("FAIL reset_tx_empty got %0b exp 1", o_tx_empty); else n_pass++;
        n_checks++; if (o_data_par !== 2'b00) $display("FAIL reset_data_par got %b exp 00", o_data_par); else n_pass++;
        n_checks++; if (o_rdi_pl_valid !== 1'b0) $display("FAIL reset_pl_valid got %0b exp 0", o_rdi_pl_valid); else n_pass++;
        i_rdi_lp_valid = 1'b0;
        i_rst_n = 1'b1;
        cycle();
        n_checks++; if (o_rdi_pl_trdy !== 1'b1) $display("FAIL post_reset_trdy got %0b exp 1", o_rdi_pl_trdy); else n_pass++;
        n_checks++; if (o_tx_empty !== 1'b1) $display("FAIL post_reset_empty got %0b exp 1", o_tx_empty); else n_pass++;
    endtask

    task automatic test_full_backpressure();
        logic [63:0] exp_seq [5] = '{64'h1, 64'h2, 64'h3, 64'h4, 64'h5};
        i_link_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            i_rdi_lp_valid = 1'b1;
            i_rdi_lp_data  = 64'(i);
            #1;
            n_checks++;
            if (o_rdi_pl_trdy !== (i <= 4)) $display("FAIL full_trdy_%0d got %0b exp %0b", i, o_rdi_pl_trdy, (i <= 4));
            else n_pass++;
            if (i <= 4) cycle();
        end
        i_link_ready = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (o_data_valid !== 1'b1 || o_data_sent !== exp_seq[k])
                $display("FAIL drain_%0d got v=%0b d=%h exp v=1 d=%h", k, o_data_valid, o_data_sent, exp_seq[k]);
            else n_pass++;
            if (k == 0) begin
                n_checks++; if (o_rdi_pl_trdy !== 1'b0) $display("FAIL full_blocks_push got %0b exp 0", o_rdi_pl_trdy); else n_pass++;
            end
            if (k == 1) begin
                n_checks++; if (o_rdi_pl_trdy !== 1'b1) $display("FAIL trdy_after_pop got %0b exp 1", o_rdi_pl_trdy); else n_pass++;
            end
            cycle();
            if (k == 1) i_rdi_lp_valid = 1'b0;
        end
        n_checks++; if (o_tx_empty !== 1'b1) $display("FAIL drain_empty got %0b exp 1", o_tx_empty); else n_pass++;
        i_link_ready = 1'b0;
    endtask

    task automatic test_parity();
        i_link_ready = 1'b0;
        i_rdi_lp_valid = 1'b1; i_rdi_lp_data = 64'h00000001_00000000;
        cycle();
        i_rdi_lp_valid = 1'b0;
        n_checks++; if (o_data_par !== 2'b10) $display("FAIL par_seg1 got %b exp 10", o_data_par); else n_pass++;
        i_link_ready = 1'b1; cycle(); i_link_ready = 1'b0;
        i_phy_req_data_error = 1'b1; cycle(); i_phy_req_data_error = 1'b0;
        i_rdi_lp_valid = 1'b1; i_rdi_lp_data = 64'h0; cycle(); i_rdi_lp_valid = 1'b0;
        n_checks++; if (o_data_par !== 2'b01) $display("FAIL par_inject got %b exp 01", o_data_par); else n_pass++;
        i_link_ready = 1'b1; cycle(); i_link_ready = 1'b0;
        i_rdi_lp_valid = 1'b1; i_rdi_lp_data = 64'h0; cycle(); i_rdi_lp_valid = 1'b0;
        n_checks++; if (o_data_par !== 2'b00) $display("FAIL par_inject_cleared got %b exp 00", o_data_par); else n_pass++;
        i_link_ready = 1'b1; cycle(); i_link_ready = 1'b0;
        n_checks++; if (o_tx_empty !== 1'b1) $display("FAIL par_empty got %0b exp 1", o_tx_empty); else n_pass++;
    endtask

    task automatic test_rx_error();
        i_data_valid = 1'b1; i_data_received = 64'h1; i_data_par = 2'b00;
        cycle();
        i_data_valid = 1'b0;
        n_checks++;
        if (o_rdi_pl_valid !== 1'b1 || o_rdi_pl_data !== 64'h1 || o_par_err !== 1'b1 || o_par_err_cnt !== 8'd1)
            $display("FAIL rx_err_first got v=%0b d=%h e=%0b c=%0d exp v=1 d=1 e=1 c=1",
                     o_rdi_pl_valid, o_rdi_pl_data, o_par_err, o_par_err_cnt);
        else n_pass++;
        cycle();
        n_checks++;
        if (o_rdi_pl_valid !== 1'b0 || o_par_err !== 1'b0 || o_rdi_pl_data !== 64'h1)
            $display("FAIL rx_idle got v=%0b e=%0b d=%h exp v=0 e=0 d=1", o_rdi_pl_valid, o_par_err, o_rdi_pl_data);
        else n_pass++;
        i_data_valid = 1'b1; i_data_received = 64'h00000001_00000003; i_data_par = 2'b10;
        cycle();
        i_data_valid = 1'b0;
        n_checks++;
        if (o_rdi_pl_valid !== 1'b1 || o_par_err !== 1'b0 || o_par_err_cnt !== 8'd1 || o_rdi_pl_data !== 64'h00000001_00000003)
            $display("FAIL rx_good got v=%0b e=%0b c=%0d d=%h exp v=1 e=0 c=1", o_rdi_pl_valid, o_par_err, o_par_err_cnt, o_rdi_pl_data);
        else n_pass++;
        i_data_valid = 1'b1; i_data_received = 64'h1; i_data_par = 2'b00;
        for (int i = 0; i < 300; i++) cycle();
        n_checks++; if (o_par_err_cnt !== 8'd255) $display("FAIL rx_saturate got %0d exp 255", o_par_err_cnt); else n_pass++;
        i_clr_err_cnt = 1'b1;
        cycle();
        i_clr_err_cnt = 1'b0;
        n_checks++;
        if (o_par_err_cnt !== 8'd0 || o_par_err !== 1'b1)
            $display("FAIL rx_clear_priority got c=%0d e=%0b exp c=0 e=1", o_par_err_cnt, o_par_err);
        else n_pass++;
        cycle();
        i_data_valid = 1'b0;
        n_checks++; if (o_par_err_cnt !== 8'd1) $display("FAIL rx_after_clear got %0d exp 1", o_par_err_cnt); else n_pass++;
        cycle();
    endtask

    task automatic test_enable_drop();
        i_link_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            i_rdi_lp_valid = 1'b1; i_rdi_lp_data = 64'h11 * 64'(i + 1);
            cycle();
        end
        i_rdi_lp_valid = 1'b0;
        n_checks++; if (o_tx_empty !== 1'b0) $display("FAIL drop_buffered got %0b exp 0", o_tx_empty); else n_pass++;
        i_enable = 1'b0;
        i_data_valid = 1'b1; i_data_received = 64'h1; i_data_par = 2'b00;
        cycle();
        i_data_valid = 1'b0;
        n_checks++; if (o_tx_empty !== 1'b1) $display("FAIL drop_empty got %0b exp 1", o_tx_empty); else n_pass++;
        n_checks++;
        if (o_rdi_pl_valid !== 1'b0 || o_par_err !== 1'b0 || o_par_err_cnt !== 8'd1)
            $display("FAIL drop_rx got v=%0b e=%0b c=%0d exp v=0 e=0 c=1", o_rdi_pl_valid, o_par_err, o_par_err_cnt);
        else n_pass++;
        i_enable = 1'b1;
        #1;
        n_checks++; if (o_data_valid !== 1'b0) $display("FAIL drop_no_stale_valid got %0b exp 0", o_data_valid); else n_pass++;
        cycle();
        n_checks++; if (o_data_valid !== 1'b0) $display("FAIL drop_still_empty got %0b exp 0", o_data_valid); else n_pass++;
        i_rdi_lp_valid = 1'b1; i_rdi_lp_data = 64'h44;
        cycle();
        i_rdi_lp_valid = 1'b0;
        n_checks++;
        if (o_data_valid !== 1'b1 || o_data_sent !== 64'h44)
            $display("FAIL drop_fresh_head got v=%0b d=%h exp v=1 d=44", o_data_valid, o_data_sent);
        else n_pass++;
        i_link_ready = 1'b1; cycle(); i_link_ready = 1'b0;
    endtask

    task automatic test_simultaneous();
        i_link_ready = 1'b0;
        i_rdi_lp_valid = 1'b1; i_rdi_lp_data = 64'hA1; cycle();
        i_rdi_lp_data = 64'hA2; cycle();
        i_rdi_lp_data = 64'hA3; i_link_ready = 1'b1;
        #1;
        n_checks++; if (o_data_sent !== 64'hA1) $display("FAIL sim_head0 got %h exp a1", o_data_sent); else n_pass++;
        cycle();
        i_rdi_lp_valid = 1'b0;
        n_checks++; if (o_data_sent !== 64'hA2) $display("FAIL sim_head1 got %h exp a2", o_data_sent); else n_pass++;
        cycle();
        n_checks++;
        if (o_data_sent !== 64'hA3 || o_tx_empty !== 1'b0)
            $display("FAIL sim_head2 got d=%h e=%0b exp d=a3 e=0", o_data_sent, o_tx_empty);
        else n_pass++;
        cycle();
        n_checks++; if (o_tx_empty !== 1'b1) $display("FAIL sim_occupancy got empty=%0b exp 1", o_tx_empty); else n_pass++;
        i_link_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_backpressure();
        test_parity();
        test_rx_error();
        test_enable_drop();
        test_simultaneous();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ucie_ctl_phy_mm_data_transfer.md
UCIE_CTL_PHY_MM_DATA_TRANSFER -- requirements
Module: ucie_ctl_phy_mm_data_transfer

Interface
REQ-001 Parameter NBYTES, default 8: RDI flit width in bytes; flit width W = NBYTES*8.
REQ-002 Parameter NMOD, default 2: number of PHY modules; NBYTES SHALL be divisible by NMOD; segment width SEG = W/NMOD.
REQ-003 Parameter DEPTH, default 4: TX FIFO depth in flits; power of 2, >= 2.
REQ-004 Parameter ERRW, default 8: parity error counter width.
REQ-005 i_clk  in  1  single clock; all state updates on its rising edge.
REQ-006 i_rst_n  in  1  reset; synchronous, active-low.
REQ-007 i_enable  in  1  link-active qualifier from the FSM control block.
REQ-008 i_rdi_lp_irdy  in  1  adapter ready to send.
REQ-009 i_rdi_lp_valid  in  1  adapter TX flit valid.
REQ-010 i_rdi_lp_data  in  W  adapter TX flit.
REQ-011 o_rdi_pl_trdy  out  1  PHY accepts the TX flit.
REQ-012 o_data_sent  out  W  flit towards link partner.
REQ-013 o_data_valid  out  1  o_data_sent valid.
REQ-014 o_data_par  out  NMOD  per-segment even parity of o_data_sent.
REQ-015 i_link_ready  in  1  link partner accepts o_data_sent.
REQ-016 i_data_received  in  W  flit from link partner.
REQ-017 i_data_valid  in  1  i_data_received valid.
REQ-018 i_data_par  in  NMOD  per-segment parity of i_data_received.
REQ-019 o_rdi_pl_valid  out  1  RX flit valid to adapter.
REQ-020 o_rdi_pl_data  out  W  RX flit to adapter.
REQ-021 i_phy_req_data_error  in  1  testbench request: corrupt parity of the next transmitted flit.
REQ-022 i_clr_err_cnt  in  1  clears the parity error counter.
REQ-023 o_par_err  out  1  one-cycle pulse: RX parity mismatch.
REQ-024 o_par_err_cnt  out  ERRW  saturating RX parity error count.
REQ-025 o_tx_empty  out  1  TX FIFO empty, used for quiescing.

Function
REQ-026 o_rdi_pl_trdy SHALL be combinational: i_enable & !tx_full.
REQ-027 Push condition: i_rdi_lp_irdy & i_rdi_lp_valid & o_rdi_pl_trdy; the flit is written at the FIFO tail.
REQ-028 The TX FIFO SHALL be first-word fall-through; o_data_valid = i_enable & !tx_empty, with 1-cycle latency from push to o_data_valid.
REQ-029 Pop condition: o_data_valid & i_link_ready; order is strictly FIFO, and pointers wrap modulo DEPTH.
REQ-030 Push and pop in the same cycle SHALL leave occupancy unchanged; full blocks push via trdy=0, and empty blocks pop.
REQ-031 o_data_par[m] SHALL be the XOR of o_data_sent[m*SEG+SEG-1 : m*SEG], computed combinationally from the FIFO head.
REQ-032 A pulse on i_phy_req_data_error SHALL set inject_pend, which inverts o_data_par[0] while set; it clears on the next pop; pulses while pending have no effect.
REQ-033 RX path: when i_enable & i_data_valid, o_rdi_pl_data <= i_data_received and o_rdi_pl_valid <= 1 (1-cycle latency, no backpressure); otherwise o_rdi_pl_valid <= 0 and o_rdi_pl_data holds.
REQ-034 The RX parity check SHALL compare per-segment XOR against i_data_par; any mismatch pulses o_par_err in the same cycle as o_rdi_pl_valid, and the data is still forwarded.
REQ-035 o_par_err_cnt SHALL increment once per erroneous flit and saturate at 2^ERRW-1; i_clr_err_cnt has priority over increment in the same cycle.
REQ-036 While i_enable=0 (each such cycle): TX FIFO pointers and occupancy clear, inject_pend clears, and RX flits are dropped; o_par_err_cnt is retained.

Reset
REQ-037 While i_rst_n=0 at a clock edge: FIFO pointers/occupancy, inject_pend, o_rdi_pl_valid, o_rdi_pl_data, o_par_err and o_par_err_cnt SHALL all be 0.
REQ-038 During and after reset (before any push): o_rdi_pl_trdy=0 during reset, o_data_valid=0, o_data_par=0, and o_tx_empty=1; reset mid-burst discards all buffered flits.

Verification (NBYTES=8, NMOD=2, DEPTH=4, ERRW=8)
REQ-039 Reset: i_rst_n=0 for 2 cycles with i_enable=1, lp_valid=1 -> trdy=0, o_data_valid=0, o_par_err_cnt=0, o_tx_empty=1.
REQ-040 Full/backpressure: i_link_ready=0, offer flits 0x01..0x05 -> 4 accepted, then trdy=0; raise i_link_ready -> o_data_sent 0x01,0x02,0x03,0x04 on consecutive cycles, and 0x05 accepted the cycle after the first pop.
REQ-041 Parity: TX flit 0x00000001_00000000 -> o_data_par=2'b10; inject pulse then TX 0x0 -> o_data_par=2'b01; next TX 0x0 -> 2'b00.
REQ-042 RX error: i_data_received=0x1, i_data_par=2'b00 -> next cycle o_rdi_pl_valid=1, data 0x1, o_par_err=1, count=1; 300 such flits -> count=255; clear and error in the same cycle -> count=0.
REQ-043 Enable drop: 3 flits buffered, i_enable=0 for 1 cycle -> o_tx_empty=1; after re-enable, no stale flit appears on o_data_sent.
REQ-044 Simultaneous: FIFO at 2 flits, push and pop in the same cycle -> occupancy stays 2 and order is preserved.
